ov7670_frame_reader: RTL and testbench

Streams one stored camera frame out of the frame-buffer BRAM in the system clock domain. It sits directly downstream of the frame-available synchronizer and consumes its synchronized level. Each fresh rising edge of that level starts one raster-order readout of WIDTH×HEIGHT pixels, presented on a valid/ready pixel stream with start-of-frame and end-of-line tags. Display, UART or other consumers sit behind this stream.

---
 rtl/ov7670_frame_reader_pkg.sv | 25 ++
 rtl/ov7670_frame_reader_if.sv | 24 ++
 rtl/ov7670_frame_reader_fifo.sv | 43 ++++
 rtl/ov7670_frame_reader.sv | 141 ++++++++++++++
 tb/tb_ov7670_frame_reader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_frame_reader_pkg.sv
// rtl/ov7670_frame_reader_pkg.sv - shared ov7670 constants, reader FSM encoding and credit helper
package ov7670_frame_reader_pkg;

  localparam logic low_p  = 1'b0;
  localparam logic high_p = 1'b1;

  localparam int QVGA_WIDTH   = 320;
  localparam int QVGA_HEIGHT  = 240;
  localparam int PIX_W_RGB565 = 16;
  localparam int QVGA_ADDR_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A read may issue while buffered + in-flight pixels stay within the 2-entry FIFO.
  function automatic logic credit_ok(input logic [1:0] occ, input logic in_flight, input logic pop);
    logic [2:0] w_sum;
    w_sum = {1'b0, occ} + {2'b00, in_flight};
    return (w_sum <= 3'd1) || ((w_sum == 3'd2) && pop);
  endfunction

endpackage

// File: rtl/ov7670_frame_reader_if.sv
// rtl/ov7670_frame_reader_if.sv - BRAM read port and pixel stream bundle for the frame reader
interface ov7670_frame_reader_if #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 17
);
  logic              Rd_En_o;
  logic [ADDR_W-1:0] Rd_Addr_o;
  logic [PIX_W-1:0]  Rd_Data_i;
  logic [PIX_W-1:0]  Pix_Data_o;
  logic              Pix_Valid_o;
  logic              Pix_Ready_i;
  logic              Pix_Sof_o;
  logic              Pix_Eol_o;

  modport master (
    output Rd_En_o, Rd_Addr_o, Pix_Data_o, Pix_Valid_o, Pix_Sof_o, Pix_Eol_o,
    input  Rd_Data_i, Pix_Ready_i
  );

  modport slave (
    input  Rd_En_o, Rd_Addr_o, Pix_Data_o, Pix_Valid_o, Pix_Sof_o, Pix_Eol_o,
    output Rd_Data_i, Pix_Ready_i
  );
endinterface

// File: rtl/ov7670_frame_reader_fifo.sv
// rtl/ov7670_frame_reader_fifo.sv - 2-entry output FIFO carrying pixel data with sof/eol tags
module ov7670_frame_reader_fifo #(
  parameter int W = 18
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/ov7670_frame_reader.sv
// rtl/ov7670_frame_reader.sv - raster readout of one stored frame per frame-available rising edge
module ov7670_frame_reader
  import ov7670_frame_reader_pkg::*;
#(
  parameter int WIDTH  = QVGA_WIDTH,
  parameter int HEIGHT = QVGA_HEIGHT,
  parameter int PIX_W  = PIX_W_RGB565,
  parameter int ADDR_W = QVGA_ADDR_W
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Frame_i,
  ov7670_frame_reader_if.master bus,
  output logic                  Busy_o,
  output logic                  Frame_Done_o,
  output logic                  Overrun_o
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_frame_q;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_in_flight;
  logic              r_if_sof;
  logic              r_if_eol;
  logic              r_overrun;
  logic              r_done;

  logic              w_rise;
  logic              w_start;
  logic              w_rd_en;
  logic              w_done_nxt;
  logic              w_pop;
  logic              w_empty;
  logic [1:0]        w_count;
  logic [PIX_W+1:0]  w_dout;

  assign w_rise = Frame_i & ~r_frame_q;
  assign w_pop  = ~w_empty & bus.Pix_Ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rd_en     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_start     = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok(w_count, r_in_flight, w_pop)) begin
          w_rd_en = 1'b1;
          if (r_addr == ADDR_LAST) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty && !r_in_flight) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_state   <= ST_IDLE;
      r_frame_q <= high_p;
      r_overrun <= low_p;
      r_done    <= low_p;
    end else begin
      r_state   <= w_state_nxt;
      r_frame_q <= Frame_i;
      r_done    <= w_done_nxt;
      // Edges outside IDLE (including the DRAIN->IDLE cycle) are lost, never queued.
      if (w_rise && r_state != ST_IDLE) r_overrun <= high_p;
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_in_flight <= low_p;
      r_if_sof    <= low_p;
      r_if_eol    <= low_p;
    end else begin
      r_in_flight <= w_rd_en;
      if (w_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_rd_en) begin
        r_if_sof <= (r_row == '0) && (r_col == '0);
        r_if_eol <= (r_col == COL_LAST);
        r_addr   <= r_addr + 1'b1;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row != ROW_LAST) r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  ov7670_frame_reader_fifo #(.W(PIX_W + 2)) u_fifo (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .push    (r_in_flight),
    .pop     (w_pop),
    .din     ({bus.Rd_Data_i, r_if_sof, r_if_eol}),
    .dout    (w_dout),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign bus.Rd_En_o     = w_rd_en;
  assign bus.Rd_Addr_o   = r_addr;
  assign bus.Pix_Data_o  = w_dout[PIX_W+1:2];
  assign bus.Pix_Valid_o = ~w_empty;
  assign bus.Pix_Sof_o   = ~w_empty & w_dout[1];
  assign bus.Pix_Eol_o   = ~w_empty & w_dout[0];
  assign Busy_o          = (r_state != ST_IDLE);
  assign Frame_Done_o    = r_done;
  assign Overrun_o       = r_overrun;

endmodule

// File: tb/tb_ov7670_frame_reader.sv
// tb/tb_ov7670_frame_reader.sv - self-checking bench for ov7670_frame_reader at 4x3
module tb_ov7670_frame_reader;
  import ov7670_frame_reader_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int PW = 16;
  localparam int AW = 4;

  typedef struct {
    int   rdy_mode;
    int   offset;
    int   ovr_at;
    logic exp_ovr;
    bit   timing;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_i;
  logic          ready;
  logic [PW-1:0] r_rd_data = '0;
  logic [PW-1:0] bram [16];
  logic          busy;
  logic          done;
  logic          ovr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int xfers, done_cnt, first_xfer, last_xfer, done_cyc;
  int my_occ, my_inflight;
  bit prev_stall;
  logic [18:0] prev_out;
  logic [17:0] sb [$];

  always #5 clk = ~clk;

  ov7670_frame_reader_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();
  assign bus.Rd_Data_i   = r_rd_data;
  assign bus.Pix_Ready_i = ready;

  ov7670_frame_reader #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .Clk_i        (clk),
    .Reset_i      (rstn),
    .Frame_i      (frame_i),
    .bus          (bus),
    .Busy_o       (busy),
    .Frame_Done_o (done),
    .Overrun_o    (ovr)
  );

  always @(posedge clk) if (bus.Rd_En_o) r_rd_data <= bram[bus.Rd_Addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.Rd_En_o, bus.Rd_Addr_o, bus.Pix_Data_o, bus.Pix_Valid_o,
                bus.Pix_Sof_o, bus.Pix_Eol_o, busy, done, ovr});
  endfunction

  task automatic reset_model();
    my_occ = 0;
    my_inflight = 0;
    prev_stall = 1'b0;
    sb.delete();
  endtask

  // One clock: drive ready, sample mid-cycle, score the cycle, advance the FIFO model.
  task automatic cycle();
    logic [18:0] cur;
    logic [17:0] exp;
    logic xfer;
    @(negedge clk);
    case (rdy_mode)
      0: ready = 1'b1;
      1: ready = ($urandom_range(0, 1) == 1);
      2: ready = ~ready;
      default: ready = 1'b0;
    endcase
    #1;
    cyc++;
    cur = {bus.Pix_Valid_o, bus.Pix_Data_o, bus.Pix_Sof_o, bus.Pix_Eol_o};
    if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
    chk("valid_vs_occupancy", 32'(bus.Pix_Valid_o), 32'(my_occ != 0));
    xfer = bus.Pix_Valid_o & ready;
    if (bus.Rd_En_o)
      chk("credit_rule", 32'((my_occ + my_inflight <= 1) || (my_occ + my_inflight == 2 && xfer)), 32'd1);
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("unexpected_pixel", 32'(xfer), 32'd0);
      end else begin
        exp = sb.pop_front();
        chk("pixel", 32'(cur[17:0]), 32'(exp));
      end
      if (xfers == 0) first_xfer = cyc;
      last_xfer = cyc;
      xfers++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 32'(busy), 32'd0);
    end
    prev_stall = bus.Pix_Valid_o & ~ready;
    prev_out = cur;
    my_occ = my_occ + my_inflight - int'(xfer);
    my_inflight = int'(bus.Rd_En_o);
  endtask

  task automatic do_reset(input logic level);
    rstn = 1'b0;
    frame_i = level;
    #1;
    reset_model();
    repeat (3) cycle();
    chk("reset_outputs", all_outs(), 32'd0);
    rstn = 1'b1;
    cycle();
  endtask

  task automatic idle(input int n);
    done_cnt = 0;
    repeat (n) cycle();
    chk("idle_no_done", 32'(done_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int mode, input int off, input int ovr_at, input int rst_at,
                           input logic exp_ovr, input bit timing);
    int e_cyc;
    bit inj;
    inj = 1'b0;
    rdy_mode = mode;
    xfers = 0;
    done_cnt = 0;
    for (int i = 0; i < N; i++) begin
      bram[i] = PW'(i + off);
      sb.push_back({PW'(i + off), (i == 0), (i % W == W - 1)});
    end
    frame_i = 1'b1;
    cycle();
    e_cyc = cyc;
    chk("start_busy_rden_addr", 32'({busy, bus.Rd_En_o, bus.Rd_Addr_o}), 32'({1'b1, 1'b1, 4'h0}));
    frame_i = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      cycle();
      if (inj) frame_i = 1'b0;
      if (ovr_at >= 0 && !inj && xfers >= ovr_at) begin
        frame_i = 1'b1;
        inj = 1'b1;
      end
      if (rst_at >= 0 && xfers >= rst_at) begin
        rstn = 1'b0;
        #1;
        chk("midframe_reset_outputs", all_outs(), 32'd0);
        reset_model();
        done_cnt = 0;
        repeat (2) cycle();
        rstn = 1'b1;
        idle(10);
        return;
      end
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("xfer_count", 32'(xfers), 32'(N));
    chk("scoreboard_left", 32'(sb.size()), 32'd0);
    chk("overrun", 32'(ovr), 32'(exp_ovr));
    if (timing) begin
      chk("first_pixel_latency", 32'(first_xfer - e_cyc), 32'd2);
      chk("contiguous_frame", 32'(last_xfer - first_xfer), 32'(N - 1));
      chk("done_after_last", 32'(done_cyc - last_xfer), 32'd2);
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{rdy_mode: 0, offset: 0,     ovr_at: -1, exp_ovr: 1'b0, timing: 1'b1};
    vecs[1] = '{rdy_mode: 1, offset: 100,   ovr_at: -1, exp_ovr: 1'b0, timing: 1'b0};
    vecs[2] = '{rdy_mode: 2, offset: 16'h5A0, ovr_at: -1, exp_ovr: 1'b0, timing: 1'b0};
    vecs[3] = '{rdy_mode: 0, offset: 0,     ovr_at: 5,  exp_ovr: 1'b1, timing: 1'b1};

    ready = 1'b1;
    do_reset(1'b0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].rdy_mode, vecs[v].offset, vecs[v].ovr_at, -1, vecs[v].exp_ovr, vecs[v].timing);
      rdy_mode = 0;
      idle(20);
      chk("overrun_after_idle", 32'(ovr), 32'(vecs[v].exp_ovr));
    end

    // Back-to-back frames: second edge sampled two cycles after the done pulse.
    do_reset(1'b0);
    run_frame(0, 0, -1, -1, 1'b0, 1'b1);
    cycle();
    run_frame(0, 48, -1, -1, 1'b0, 1'b1);
    idle(5);
    chk("b2b_overrun", 32'(ovr), 32'd0);

    // Frame_i high through reset release starts nothing until a fresh rise.
    do_reset(1'b1);
    idle(20);
    frame_i = 1'b0;
    cycle();
    run_frame(0, 7, -1, -1, 1'b0, 1'b1);
    idle(5);

    // Reset at pixel 6, then a clean restart from pixel 0.
    do_reset(1'b0);
    run_frame(0, 0, -1, 6, 1'b0, 1'b0);
    run_frame(1, 3, -1, -1, 1'b0, 1'b0);
    rdy_mode = 0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
